// File: rtl/riscv_core_cache_pkg.sv
// rtl/riscv_core_cache_pkg.sv - shared D-cache field geometry, FSM states and address helpers
package riscv_core_cache_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int INDEX_WIDTH  = 7;
  localparam int BLOCK_OFFSET = 2;
  localparam int OFFSET_WIDTH = BLOCK_OFFSET + 3;
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int INDEX_LSB    = OFFSET_WIDTH;
  localparam int TAG_LSB      = INDEX_LSB + INDEX_WIDTH;
  localparam int NUM_LINES    = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FILL_REQ,
    RESP,
    WR_WAIT,
    FLUSH
  } dcache_state_e;

  function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[TAG_LSB-1:INDEX_LSB];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:TAG_LSB];
  endfunction

endpackage

// File: rtl/riscv_core_dcache_ctrl_if.sv
// rtl/riscv_core_dcache_ctrl_if.sv - core, data-memory and AXI-adapter signals of the D-cache controller
interface riscv_core_dcache_ctrl_if;
  import riscv_core_cache_pkg::*;

  logic                  i_req_valid;
  logic                  i_req_we;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [1:0]            i_req_size;
  logic [31:0]           i_req_wdata;
  logic                  i_flush;
  logic                  o_ack;
  logic                  o_stall;
  logic                  o_mem_rd_en;
  logic                  o_mem_wr_en;
  logic                  o_mem_replace;
  logic                  o_axi_rd_req;
  logic [ADDR_WIDTH-1:0] o_axi_rd_addr;
  logic                  i_axi_rd_valid;
  logic                  o_axi_wr_req;
  logic [ADDR_WIDTH-1:0] o_axi_wr_addr;
  logic [31:0]           o_axi_wr_data;
  logic [1:0]            o_axi_wr_size;
  logic                  i_axi_wr_done;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_wdata, i_flush,
    input  i_axi_rd_valid, i_axi_wr_done,
    output o_ack, o_stall, o_mem_rd_en, o_mem_wr_en, o_mem_replace,
    output o_axi_rd_req, o_axi_rd_addr, o_axi_wr_req, o_axi_wr_addr, o_axi_wr_data, o_axi_wr_size
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_wdata, i_flush,
    output i_axi_rd_valid, i_axi_wr_done,
    input  o_ack, o_stall, o_mem_rd_en, o_mem_wr_en, o_mem_replace,
    input  o_axi_rd_req, o_axi_rd_addr, o_axi_wr_req, o_axi_wr_addr, o_axi_wr_data, o_axi_wr_size
  );

endinterface

// File: rtl/riscv_core_dcache_tag_array.sv
// rtl/riscv_core_dcache_tag_array.sv - valid bits and tags, one read, one write and one clear port
module riscv_core_dcache_tag_array
  import riscv_core_cache_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [INDEX_WIDTH-1:0] rd_idx_i,
  output logic                   rd_valid_o,
  output logic [TAG_WIDTH-1:0]   rd_tag_o,
  input  logic                   wr_en_i,
  input  logic [INDEX_WIDTH-1:0] wr_idx_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic                   clr_en_i,
  input  logic [INDEX_WIDTH-1:0] clr_idx_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_WIDTH-1:0] tag_q [NUM_LINES];

  // Valid bits: cleared by reset or flush walk, set by a completed line fill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_en_i) valid_q[clr_idx_i] <= 1'b0;
      if (wr_en_i)  valid_q[wr_idx_i]  <= 1'b1;
    end
  end

  // Tags need no reset: they are only meaningful behind a set valid bit.
  always_ff @(posedge i_clk) begin
    if (wr_en_i) tag_q[wr_idx_i] <= wr_tag_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/riscv_core_dcache_ctrl.sv
// rtl/riscv_core_dcache_ctrl.sv - write-through, read-allocate direct-mapped D-cache controller
module riscv_core_dcache_ctrl
  import riscv_core_cache_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  riscv_core_dcache_ctrl_if.slave bus
);

  dcache_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [1:0]             size_q, size_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic                   flush_pend_q, flush_pend_d;

  logic                   arr_valid;
  logic [TAG_WIDTH-1:0]   arr_tag;
  logic                   hit;
  logic                   tag_wr, clr;
  logic                   ack, rd_en, wr_en, replace, axi_rd_req, axi_wr_req;

  riscv_core_dcache_tag_array u_tag_array (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .rd_idx_i   (addr_index(bus.i_req_addr)),
    .rd_valid_o (arr_valid),
    .rd_tag_o   (arr_tag),
    .wr_en_i    (tag_wr),
    .wr_idx_i   (addr_index(addr_q)),
    .wr_tag_i   (addr_tag(addr_q)),
    .clr_en_i   (clr),
    .clr_idx_i  (cnt_q)
  );

  assign hit = arr_valid & (arr_tag == addr_tag(bus.i_req_addr));

  // State, request latch, flush counter and pending-flush flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state and per-state strobes; a flush seen outside IDLE is remembered.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q | bus.i_flush;
    ack          = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    replace      = 1'b0;
    axi_rd_req   = 1'b0;
    axi_wr_req   = 1'b0;
    tag_wr       = 1'b0;
    clr          = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_pend_q | bus.i_flush) begin
          state_d      = FLUSH;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (bus.i_req_valid) begin
          if (bus.i_req_we) begin
            addr_d  = bus.i_req_addr;
            wdata_d = bus.i_req_wdata;
            size_d  = bus.i_req_size;
            wr_en   = hit;
            state_d = WR_WAIT;
          end else if (hit) begin
            rd_en = 1'b1;
            ack   = 1'b1;
          end else begin
            addr_d  = bus.i_req_addr;
            state_d = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        axi_rd_req = 1'b1;
        if (bus.i_axi_rd_valid) begin
          wr_en   = 1'b1;
          replace = 1'b1;
          tag_wr  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rd_en   = 1'b1;
        ack     = 1'b1;
        state_d = IDLE;
      end
      WR_WAIT: begin
        axi_wr_req = 1'b1;
        if (bus.i_axi_wr_done) begin
          ack     = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        clr   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {INDEX_WIDTH{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ack         = ack;
  assign bus.o_stall       = (bus.i_req_valid & ~ack) | (state_q != IDLE);
  assign bus.o_mem_rd_en   = rd_en;
  assign bus.o_mem_wr_en   = wr_en;
  assign bus.o_mem_replace = replace;
  assign bus.o_axi_rd_req  = axi_rd_req;
  assign bus.o_axi_rd_addr = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign bus.o_axi_wr_req  = axi_wr_req;
  assign bus.o_axi_wr_addr = addr_q;
  assign bus.o_axi_wr_data = wdata_q;
  assign bus.o_axi_wr_size = size_q;

endmodule

// File: tb/tb_riscv_core_dcache_ctrl.sv
// tb/tb_riscv_core_dcache_ctrl.sv - self-checking bench for the D-cache controller
module tb_riscv_core_dcache_ctrl;
  import riscv_core_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bit          m_valid [128];
  logic [19:0] m_tag   [128];

  riscv_core_dcache_ctrl_if bus();

  riscv_core_dcache_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[11:5]] && (m_tag[a[11:5]] == a[31:12]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] addr, input int lat, output bit hit_seen);
    bit exp;
    exp = model_hit(addr);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = addr;
    bus.i_req_size  = 2'b10;
    @(negedge clk);
    hit_seen = bus.o_ack;
    checks++;
    if (bus.o_ack !== exp) begin
      errors++; $display("FAIL load_hit addr=%h got ack=%b exp %b", addr, bus.o_ack, exp);
    end
    if (exp) begin
      checks++;
      if ({bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_axi_rd_req, bus.o_stall} !== 4'b1000) begin
        errors++; $display("FAIL load_hit_sig addr=%h got rd/wr/axi/stall=%b exp 1000", addr,
                            {bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_axi_rd_req, bus.o_stall});
      end
    end else begin
      checks++;
      if ({bus.o_stall, bus.o_mem_rd_en, bus.o_mem_wr_en} !== 3'b100) begin
        errors++; $display("FAIL load_miss_idle got stall/rd/wr=%b exp 100",
                            {bus.o_stall, bus.o_mem_rd_en, bus.o_mem_wr_en});
      end
      for (int i = 0; i < lat; i++) begin
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus.o_axi_rd_req, bus.o_ack, bus.o_mem_wr_en} !== 3'b100 ||
            bus.o_axi_rd_addr !== {addr[31:5], 5'b0}) begin
          errors++; $display("FAIL fill_wait got req/ack/wr=%b addr=%h exp 100 addr=%h",
                              {bus.o_axi_rd_req, bus.o_ack, bus.o_mem_wr_en}, bus.o_axi_rd_addr,
                              {addr[31:5], 5'b0});
        end
      end
      next_cycle();
      bus.i_axi_rd_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.o_mem_wr_en, bus.o_mem_replace, bus.o_mem_rd_en, bus.o_ack, bus.o_axi_rd_req} !== 5'b11001 ||
          bus.o_axi_rd_addr !== {addr[31:5], 5'b0}) begin
        errors++; $display("FAIL fill_replace got wr/rep/rd/ack/req=%b addr=%h exp 11001 addr=%h",
                            {bus.o_mem_wr_en, bus.o_mem_replace, bus.o_mem_rd_en, bus.o_ack, bus.o_axi_rd_req},
                            bus.o_axi_rd_addr, {addr[31:5], 5'b0});
      end
      next_cycle();
      bus.i_axi_rd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.o_ack, bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_mem_replace, bus.o_axi_rd_req} !== 5'b11000) begin
        errors++; $display("FAIL fill_resp got ack/rd/wr/rep/req=%b exp 11000",
                            {bus.o_ack, bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_mem_replace, bus.o_axi_rd_req});
      end
      m_valid[addr[11:5]] = 1'b1;
      m_tag[addr[11:5]]   = addr[31:12];
    end
    next_cycle();
    bus.i_req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                          input int wlat, input bit flush_mid, output bit wr_seen);
    bit exp;
    exp = model_hit(addr);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_req_addr  = addr;
    bus.i_req_size  = size;
    bus.i_req_wdata = data;
    @(negedge clk);
    wr_seen = bus.o_mem_wr_en;
    checks++;
    if ({bus.o_mem_wr_en, bus.o_mem_replace, bus.o_mem_rd_en, bus.o_ack, bus.o_stall} !== {exp, 4'b0001}) begin
      errors++; $display("FAIL store_idle addr=%h got wr/rep/rd/ack/stall=%b exp %b", addr,
                          {bus.o_mem_wr_en, bus.o_mem_replace, bus.o_mem_rd_en, bus.o_ack, bus.o_stall},
                          {exp, 4'b0001});
    end
    for (int i = 0; i < wlat; i++) begin
      next_cycle();
      bus.i_flush = (flush_mid && i == 0);
      @(negedge clk);
      checks++;
      if ({bus.o_axi_wr_req, bus.o_ack, bus.o_mem_wr_en} !== 3'b100 || bus.o_axi_wr_addr !== addr ||
          bus.o_axi_wr_data !== data || bus.o_axi_wr_size !== size) begin
        errors++; $display("FAIL wr_wait got req/ack/wr=%b a=%h d=%h s=%b exp 100 a=%h d=%h s=%b",
                            {bus.o_axi_wr_req, bus.o_ack, bus.o_mem_wr_en}, bus.o_axi_wr_addr,
                            bus.o_axi_wr_data, bus.o_axi_wr_size, addr, data, size);
      end
    end
    next_cycle();
    bus.i_flush       = 1'b0;
    bus.i_axi_wr_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_axi_wr_req, bus.o_ack, bus.o_mem_wr_en, bus.o_mem_rd_en} !== 4'b1100) begin
      errors++; $display("FAIL wr_done got req/ack/wr/rd=%b exp 1100",
                          {bus.o_axi_wr_req, bus.o_ack, bus.o_mem_wr_en, bus.o_mem_rd_en});
    end
    next_cycle();
    bus.i_axi_wr_done = 1'b0;
    bus.i_req_valid   = 1'b0;
  endtask

  // Entered right after the IDLE cycle that accepted the flush; counts stalled cycles.
  task automatic expect_flush_run();
    int n;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.o_stall) break;
      n++;
      next_cycle();
    end
    checks++;
    if (n != 128) begin
      errors++; $display("FAIL flush_len got %0d cycles exp 128", n);
    end
    model_clear();
    next_cycle();
  endtask

  task automatic do_flush_idle();
    bus.i_flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_stall, bus.o_ack} !== 2'b00) begin
      errors++; $display("FAIL flush_idle got stall/ack=%b exp 00", {bus.o_stall, bus.o_ack});
    end
    next_cycle();
    bus.i_flush = 1'b0;
    expect_flush_run();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.o_ack, bus.o_stall, bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_mem_replace, bus.o_axi_rd_req,
         bus.o_axi_rd_addr, bus.o_axi_wr_req, bus.o_axi_wr_addr, bus.o_axi_wr_data, bus.o_axi_wr_size} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero ack=%b stall=%b rdreq=%b wrreq=%b exp all 0",
                          bus.o_ack, bus.o_stall, bus.o_axi_rd_req, bus.o_axi_wr_req);
    end
    next_cycle();
    rst_n = 1'b1;
    model_clear();
    next_cycle();
  endtask

  task automatic test_cold_and_repeat();
    bit h;
    do_load(32'h0000_1234, 5, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL cold_load got hit=%b exp 0", h); end
    do_load(32'h0000_1238, 3, h);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL repeat_load got hit=%b exp 1", h); end
  endtask

  task automatic test_store_hit_miss();
    bit w, h;
    do_store(32'h0000_1234, 32'hDEAD_BEEF, 2'b10, 2, 1'b0, w);
    checks++;
    if (w !== 1'b1) begin errors++; $display("FAIL store_hit got mem_wr=%b exp 1", w); end
    do_load(32'h0000_1234, 2, h);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL reload_after_store got hit=%b exp 1", h); end
    do_store(32'h0000_5000, 32'h1234_5678, 2'b01, 1, 1'b0, w);
    checks++;
    if (w !== 1'b0) begin errors++; $display("FAIL store_miss got mem_wr=%b exp 0", w); end
    do_load(32'h0000_5000, 1, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL load_after_store_miss got hit=%b exp 0", h); end
  endtask

  task automatic test_conflict();
    bit h1, h2, h3;
    do_load(32'h0000_0040, 0, h1);
    do_load(32'h0000_1040, 2, h2);
    do_load(32'h0000_0040, 1, h3);
    checks++;
    if ({h1, h2, h3} !== 3'b000) begin
      errors++; $display("FAIL conflict got hits=%b exp 000", {h1, h2, h3});
    end
  endtask

  task automatic test_flush_in_wr_wait();
    bit w, h;
    do_store(32'h0000_1238, 32'h0BAD_F00D, 2'b10, 2, 1'b1, w);
    @(negedge clk);
    checks++;
    if (bus.o_stall !== 1'b0) begin errors++; $display("FAIL flush_pend_idle got stall=%b exp 0", bus.o_stall); end
    next_cycle();
    expect_flush_run();
    do_load(32'h0000_1234, 1, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL after_flush got hit=%b exp 0", h); end
  endtask

  task automatic test_reset_mid_fill();
    bit h;
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = 32'h0000_3460;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.o_axi_rd_req !== 1'b1) begin errors++; $display("FAIL mid_fill_req got %b exp 1", bus.o_axi_rd_req); end
    #2;
    rst_n = 1'b0;
    bus.i_req_valid = 1'b0;
    #1;
    checks++;
    if ({bus.o_ack, bus.o_stall, bus.o_mem_rd_en, bus.o_mem_wr_en, bus.o_mem_replace, bus.o_axi_rd_req,
         bus.o_axi_rd_addr, bus.o_axi_wr_req, bus.o_axi_wr_addr, bus.o_axi_wr_data, bus.o_axi_wr_size} !== '0) begin
      errors++; $display("FAIL reset_mid_fill got stall=%b rdreq=%b rdaddr=%h exp all 0",
                          bus.o_stall, bus.o_axi_rd_req, bus.o_axi_rd_addr);
    end
    next_cycle();
    rst_n = 1'b1;
    model_clear();
    next_cycle();
    do_load(32'h0000_3460, 1, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL line_after_reset got hit=%b exp 0", h); end
  endtask

  task automatic test_random();
    bit r;
    logic [31:0] a;
    for (int n = 0; n < 120; n++) begin
      a = {10'd0, 10'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 5'($urandom_range(0, 7) << 2)};
      case ($urandom_range(0, 19))
        0:               do_flush_idle();
        1, 2, 3, 4, 5:   do_store(a, $urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 3), 1'b0, r);
        default:         do_load(a, $urandom_range(0, 4), r);
      endcase
    end
  endtask

  initial begin
    bus.i_req_valid    = 1'b0;
    bus.i_req_we       = 1'b0;
    bus.i_req_addr     = '0;
    bus.i_req_size     = '0;
    bus.i_req_wdata    = '0;
    bus.i_flush        = 1'b0;
    bus.i_axi_rd_valid = 1'b0;
    bus.i_axi_wr_done  = 1'b0;
    test_reset();
    test_cold_and_repeat();
    test_store_hit_miss();
    test_conflict();
    test_flush_in_wr_wait();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
